// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes, sequencer state encoding and datapath width shared by mult_seq
package alu_pkg;
    localparam int DATA_W = 32;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/mult_seq_if.sv
// mult_seq_if: multiply request/result, datapath ALU request and alu32 port bundle
interface mult_seq_if;
    import alu_pkg::*;
    logic              start;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              busy;
    logic              dp_stall;
    logic              done;
    logic [DATA_W-1:0] prod_hi;
    logic [DATA_W-1:0] prod_lo;
    logic [DATA_W-1:0] dp_a;
    logic [DATA_W-1:0] dp_b;
    logic [2:0]        dp_cont;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [2:0]        alu_cont;
    logic [DATA_W-1:0] alu_res;
    modport master (
        output start, op_a, op_b, dp_a, dp_b, dp_cont, alu_res,
        input  busy, dp_stall, done, prod_hi, prod_lo, alu_a, alu_b, alu_cont
    );
    modport slave (
        input  start, op_a, op_b, dp_a, dp_b, dp_cont, alu_res,
        output busy, dp_stall, done, prod_hi, prod_lo, alu_a, alu_b, alu_cont
    );
endinterface

// File: rtl/mult_seq_alu_port_mux.sv
// alu_port_mux: hands the alu32 ports to the multiplier while busy, else to the datapath
module alu_port_mux
    import alu_pkg::*;
(
    input  logic              sel,
    input  logic [DATA_W-1:0] dp_a,
    input  logic [DATA_W-1:0] dp_b,
    input  logic [2:0]        dp_cont,
    input  logic [DATA_W-1:0] run_a,
    input  logic [DATA_W-1:0] run_b,
    input  logic [2:0]        run_cont,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_cont
);
    always_comb begin
        alu_a    = sel ? run_a : dp_a;
        alu_b    = sel ? run_b : dp_b;
        alu_cont = sel ? run_cont : dp_cont;
    end
endmodule

// File: rtl/mult_seq.sv
// mult_seq: 32x32 shift-add multiplier on the shared alu32 adder; MULT_ZERO_BYPASS_EN skips zero operands
module mult_seq
    import alu_pkg::*;
#(
    parameter logic [2:0] ADD_CODE = ALU_ADD
) (
    input  logic        clk,
    input  logic        rst,
    mult_seq_if.slave   m
);
    state_t            state_q, state_d;
    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d;
    logic [DATA_W-1:0] prod_hi_q, prod_hi_d, prod_lo_q, prod_lo_d;
    logic [4:0]        count_q, count_d;
    logic [DATA_W-1:0] sum, hi_nx, lo_nx;
    logic              carry, cy, zero_op, busy;
`ifdef MULT_ZERO_BYPASS_EN
    assign zero_op = (m.op_a == '0) || (m.op_b == '0);
`else
    assign zero_op = 1'b0;
`endif
    assign busy       = state_q == RUN;
    assign m.busy     = busy;
    assign m.dp_stall = busy;
    assign m.done     = state_q == DONE;
    assign m.prod_hi  = prod_hi_q;
    assign m.prod_lo  = prod_lo_q;
    alu_port_mux u_mux (
        .sel      (busy),
        .dp_a     (m.dp_a),
        .dp_b     (m.dp_b),
        .dp_cont  (m.dp_cont),
        .run_a    (hi_q),
        .run_b    (mcand_q),
        .run_cont (ADD_CODE),
        .alu_a    (m.alu_a),
        .alu_b    (m.alu_b),
        .alu_cont (m.alu_cont)
    );
    // alu32 has no carry out, so rebuild it from the operand and result MSBs
    always_comb begin
        carry = (hi_q[DATA_W-1] & mcand_q[DATA_W-1]) |
                ((hi_q[DATA_W-1] | mcand_q[DATA_W-1]) & ~m.alu_res[DATA_W-1]);
        sum   = lo_q[0] ? m.alu_res : hi_q;
        cy    = lo_q[0] & carry;
        hi_nx = {cy, sum[DATA_W-1:1]};
        lo_nx = {sum[0], lo_q[DATA_W-1:1]};
    end
    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        mcand_d   = mcand_q;
        count_d   = count_q;
        prod_hi_d = prod_hi_q;
        prod_lo_d = prod_lo_q;
        case (state_q)
            IDLE: if (m.start) begin
                if (zero_op) begin
                    state_d   = DONE;
                    prod_hi_d = '0;
                    prod_lo_d = '0;
                end else begin
                    state_d = RUN;
                    hi_d    = '0;
                    lo_d    = m.op_b;
                    mcand_d = m.op_a;
                    count_d = '0;
                end
            end
            RUN: begin
                hi_d    = hi_nx;
                lo_d    = lo_nx;
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    state_d   = DONE;
                    prod_hi_d = hi_nx;
                    prod_lo_d = lo_nx;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            mcand_q   <= '0;
            count_q   <= '0;
            prod_hi_q <= '0;
            prod_lo_q <= '0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            mcand_q   <= mcand_d;
            count_q   <= count_d;
            prod_hi_q <= prod_hi_d;
            prod_lo_q <= prod_lo_d;
        end
    end
endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: directed vectors for mult_seq with an alu32 behavioural model on the ALU ports
module tb_mult_seq;
    import alu_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [31:0] prev_hi = '0, prev_lo = '0;
`ifdef MULT_ZERO_BYPASS_EN
    localparam int ZLAT = 1, ZBC = 0;
`else
    localparam int ZLAT = 33, ZBC = 32;
`endif
    mult_seq_if intf ();
    mult_seq dut (.clk(clk), .rst(rst), .m(intf.slave));
    always #5 clk = ~clk;
    always_comb begin
        intf.alu_res = intf.alu_cont == ALU_ADD ? intf.alu_a + intf.alu_b :
                       intf.alu_cont == ALU_SUB ? intf.alu_a - intf.alu_b :
                       intf.alu_cont == ALU_AND ? intf.alu_a & intf.alu_b :
                       intf.alu_cont == ALU_OR  ? intf.alu_a | intf.alu_b : '0;
    end
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic mul(input logic [31:0] a, b, exp_hi, exp_lo, input int exp_lat, exp_bc, pulse_at);
        int n = 0, bc = 0;
        bit got_done = 0;
        @(negedge clk);
        intf.op_a = a;
        intf.op_b = b;
        intf.start = 1'b1;
        @(posedge clk);
        while (!got_done && n < 100) begin
            @(negedge clk);
            intf.start = 1'b0;
            n++;
            if (n == 1 && exp_lat > 1) check("prod_held", {intf.prod_hi, intf.prod_lo}, {prev_hi, prev_lo});
            if (n == 2 && exp_lat > 2) begin
                check("run_alu_cont", 64'(intf.alu_cont), 64'(ALU_ADD));
                check("run_dp_stall", 64'(intf.dp_stall), 64'd1);
            end
            if (n == pulse_at) begin
                intf.start = 1'b1;
                intf.op_a = ~a;
                intf.op_b = ~b;
            end
            if (intf.busy) bc++;
            if (intf.done) got_done = 1;
        end
        check("latency", 64'(n), 64'(exp_lat));
        check("busy_cycles", 64'(bc), 64'(exp_bc));
        check("product", {intf.prod_hi, intf.prod_lo}, {exp_hi, exp_lo});
        intf.start = 1'b1;
        @(negedge clk);
        intf.start = 1'b0;
        check("start_in_done_ignored", 64'(intf.busy), 64'd0);
        check("done_one_cycle", 64'(intf.done), 64'd0);
        prev_hi = exp_hi;
        prev_lo = exp_lo;
    endtask
    initial begin
        intf.start = 1'b0;
        intf.op_a = '0;
        intf.op_b = '0;
        intf.dp_a = '0;
        intf.dp_b = '0;
        intf.dp_cont = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 64'(intf.busy), 64'd0);
        check("rst_done", 64'(intf.done), 64'd0);
        check("rst_prod", {intf.prod_hi, intf.prod_lo}, 64'd0);
        intf.dp_a = 32'd7;
        intf.dp_b = 32'd2;
        intf.dp_cont = 3'b110;
        #1;
        check("idle_alu_a", 64'(intf.alu_a), 64'd7);
        check("idle_alu_b", 64'(intf.alu_b), 64'd2);
        check("idle_alu_cont", 64'(intf.alu_cont), 64'(3'b110));
        check("idle_alu_res", 64'(intf.alu_res), 64'd5);
        mul(32'd3, 32'd5, 32'h0, 32'hF, 33, 32, -1);
        mul(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 32, -1);
        mul(32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000, 33, 32, -1);
        mul(32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 33, 32, -1);
        mul(32'h00001234, 32'h00005678, 32'h0, 32'h06260060, 33, 32, 10);
        @(negedge clk);
        intf.op_a = 32'd3;
        intf.op_b = 32'd5;
        intf.start = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            intf.start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(intf.busy), 64'd0);
        check("abort_done", 64'(intf.done), 64'd0);
        check("abort_prod", {intf.prod_hi, intf.prod_lo}, 64'd0);
        prev_hi = '0;
        prev_lo = '0;
        mul(32'd0, 32'h00001234, 32'h0, 32'h0, ZLAT, ZBC, -1);
        mul(32'hDEADBEEF, 32'd1, 32'h0, 32'hDEADBEEF, 33, 32, -1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
